uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: 8N1 framing, LSB first, runtime-programmable bit period. It pairs with the existing `UART_TX`, which drives the same line format. It sits inside the bamse I/O port block as the `rx_uart` source and presents received bytes to the PicoBlaze input-port mux with a read-strobe handshake. A 2-FF synchronizer, mid-bit sampling, glitch rejection and framing/overrun detection are included.

## Interface
- `CLKS_W`, 12, width of bit-period count; matches `i_Clk_per_bit`.
- `FIFO_AW`, 2, log2 receive FIFO depth; used only with `UART_RX_FIFO_EN`.
- `i_Clock`  in  1  system clock (32 MHz on Papilio Duo).
- `i_Rst_H`  in  1  reset. One clock; reset is asynchronous and active-high.
- `i_RX_Serial`  in  1  serial line; asynchronous, idle high.
- `i_Clk_per_bit`  in  CLKS_W  clocks per bit; captured at start detection; legal range ≥ 4 (0xD05 = 9600 baud at 32 MHz).
- `i_RX_Rd`  in  1  one-cycle pop strobe; ignored when `o_RX_Ready`=0.
- `o_RX_Byte`  out  8  oldest unread byte; valid while `o_RX_Ready`=1.
- `o_RX_Ready`  out  1  at least one unread byte held.
- `o_RX_Done`  out  1  one-cycle pulse per byte accepted into storage.
- `o_RX_Active`  out  1  high from start detection until leaving STOP.
- `o_RX_Frame_Err`  out  1  one-cycle pulse when the stop bit samples low.
- `o_RX_Overrun`  out  1  sticky; set when a byte is dropped because storage is full; cleared by `i_RX_Rd` or reset.

## Operation
- Reset: all outputs 0; `o_RX_Byte`=0x00; state IDLE; synchronizer flops preset to 1.
- `i_RX_Serial` passes through 2 flops (`rx_s`); all decisions use `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: `rx_s`=0 → latch `cpb`=`i_Clk_per_bit`, clear counter, → START, `o_RX_Active`=1.
- START: counter reaches `(cpb>>1)-1` → sample. If `rx_s`=1 (glitch), → IDLE with no flags. Otherwise clear counter, bit index=0, → DATA.
- DATA: counter reaches `cpb-1` → shift `rx_s` into bit[index] (LSB first) and clear counter. At index 7, → STOP; otherwise index+1.
- STOP: counter reaches `cpb-1` → sample. If `rx_s`=1, push byte → IDLE. If `rx_s`=0, discard byte, pulse `o_RX_Frame_Err`, → WAIT_HIGH.
- WAIT_HIGH: stays until `rx_s`=1, then → IDLE. This covers the break condition: no spurious start while the line is held low.
- Push when storage full: byte dropped, `o_RX_Overrun` set, no `o_RX_Done`.
- Push and `i_RX_Rd` in the same cycle:
  - Pop is applied first, so no overrun occurs even when full.
  - `o_RX_Overrun` clear (by read) has priority over set only if no drop occurs.
- `i_Clk_per_bit` changes mid-frame have no effect until the next start.
- Reset mid-frame: immediate return to IDLE. Partial byte, storage and flags are cleared.
- Counter width is CLKS_W. `cpb` < 4 is illegal and behaviour is undefined.

## Timing
- Pin falling edge to START entry: 2 cycles (synchronizer) + 1.
- Start-bit centre: START entry + `cpb>>1` cycles. Each later sample is `cpb` cycles apart.
- `o_RX_Done`, `o_RX_Ready` rise and `o_RX_Byte` updates 1 cycle after the stop-bit sample.
- Total pin-edge to `o_RX_Done` ≈ 3 + (cpb>>1) + 9·cpb cycles.
- `i_RX_Rd` at edge N: next byte (or `o_RX_Ready`=0) visible after edge N.
- `o_RX_Frame_Err` pulses in the cycle after the stop sample.

## Configuration
- `UART_RX_FIFO_EN` defined: storage is a 2^FIFO_AW-entry FIFO (default 4). `o_RX_Ready`=not empty; overrun only when all entries are full.
- Not defined: storage is a single holding register plus a valid flag. A second byte arriving before a read is dropped with overrun set. Ports are identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4);
  - `CLKS_W`;
  - baud constant `CPB_9600_32M`=12'hD05.
- Sub-module `uart_rx_fifo` (synchronous FIFO with push/pop/full/empty and simultaneous push+pop) is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- `UART_TX` at `i_Clk_per_bit`=0xD05 sends 0xAF → one `o_RX_Done` pulse; `o_RX_Byte`=0xAF, `o_RX_Ready`=1; `i_RX_Rd` → `o_RX_Ready`=0.
- cpb=16, back-to-back 0x55 then 0xCD with no reads:
  - single register: `o_RX_Byte`=0x55, `o_RX_Overrun`=1;
  - FIFO: reads return 0x55, 0xCD, no overrun.
- Low pulse of 5 cycles on line at cpb=16 → no `o_RX_Active` after START, no Done, no error.
- Frame with stop bit 0 (0x3C, line held low 3·cpb) → `o_RX_Frame_Err` pulse, no Done; next valid 0x81 after line high is received correctly.
- Assert `i_Rst_H` during DATA bit 4 → outputs 0 immediately; the following full frame 0xA5 is received.
- Push coinciding with `i_RX_Rd` on full storage → no overrun; the popped byte is the oldest; the new byte is stored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, bit-period width
// and the standard baud constant.
package uart_pkg;

  localparam int CLKS_W = 12;

  // 9600 baud from the 32 MHz Papilio Duo clock
  localparam logic [CLKS_W-1:0] CPB_9600_32M = 12'hD05;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line, bit period and the read-strobe byte handshake.
interface uart_rx_if #(parameter int CLKS_W = uart_pkg::CLKS_W);

  logic              rx_serial;
  logic [CLKS_W-1:0] clk_per_bit;
  logic              rx_rd;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic              rx_done;
  logic              rx_active;
  logic              rx_frame_err;
  logic              rx_overrun;

  // master is the consumer side (line source and port reader); slave is the receiver
  modport master (
    output rx_serial, clk_per_bit, rx_rd,
    input  rx_byte, rx_ready, rx_done, rx_active, rx_frame_err, rx_overrun
  );

  modport slave (
    input  rx_serial, clk_per_bit, rx_rd,
    output rx_byte, rx_ready, rx_done, rx_active, rx_frame_err, rx_overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO for the receiver; a pop frees space for a push in the
// same cycle, so a full FIFO can accept a byte while it is being read.
module uart_rx_fifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);
  import uart_pkg::*;

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch and break handling, and a
// read-strobe output. Define UART_RX_FIFO_EN for a FIFO instead of one holding register.
module uart_rx #(
  parameter int CLKS_W = uart_pkg::CLKS_W
`ifdef UART_RX_FIFO_EN
  , parameter int FIFO_AW = 2
`endif
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.slave  bus
);
  import uart_pkg::*;

  logic [1:0]        sync;
  logic              rx_s;
  rx_state_t         state, state_nxt;
  logic [CLKS_W-1:0] cnt, cnt_nxt;
  logic [CLKS_W-1:0] cpb, cpb_nxt;
  logic [CLKS_W-1:0] half_last;
  logic [CLKS_W-1:0] cpb_last;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift_reg, shift_nxt;
  logic              frame_err_q, frame_err_nxt;
  logic              push;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              done_q;
  logic              overrun_q;

  // Presetting to 1 keeps an idle line from looking like a start bit out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], bus.rx_serial};
  end

  assign rx_s      = sync[1];
  assign half_last = (cpb >> 1) - 1'b1;
  assign cpb_last  = cpb - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cpb         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cpb         <= cpb_nxt;
      bit_idx     <= bit_idx_nxt;
      shift_reg   <= shift_nxt;
      frame_err_q <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 1'b1;
    cpb_nxt       = cpb;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift_reg;
    frame_err_nxt = 1'b0;
    push          = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          cpb_nxt   = bus.clk_per_bit;
          state_nxt = START;
        end
      end
      START: begin
        // A line that is high again at the start-bit centre was only a glitch
        if (cnt == half_last) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            bit_idx_nxt = '0;
            state_nxt   = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == cpb_last) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (cnt == cpb_last) begin
          cnt_nxt       = '0;
          push          = rx_s;
          frame_err_nxt = !rx_s;
          state_nxt     = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // Break: hold off start detection until the line returns high
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  assign pop    = bus.rx_rd && !fifo_empty;
  assign accept = push && (!fifo_full || pop);
  assign drop   = push && !accept;

  uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (shift_reg),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.rx_ready = !fifo_empty;
  assign bus.rx_byte  = fifo_dout;
`else
  logic       hold_valid;
  logic [7:0] hold_byte;

  assign pop    = bus.rx_rd && hold_valid;
  assign accept = push && (!hold_valid || pop);
  assign drop   = push && !accept;

  // A same-cycle read frees the register, so the new byte replaces the one being read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_byte  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_byte  <= shift_reg;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign bus.rx_ready = hold_valid;
  assign bus.rx_byte  = hold_byte;
`endif

  // A drop in the same cycle as a read still leaves overrun set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= accept;
      if (drop)     overrun_q <= 1'b1;
      else if (pop) overrun_q <= 1'b0;
    end
  end

  assign bus.rx_done      = done_q;
  assign bus.rx_overrun   = overrun_q;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_active    = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a bit-banged 8N1 transmitter drives the line, expected bytes go
// into a scoreboard queue and are compared as the port is read.
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_FIFO_EN
  localparam int STORE_DEPTH = 4;
`else
  localparam int STORE_DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_rx_if bus ();

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors      = 0;
  int miscompares  = 0;
  int doneCount    = 0;
  int ferrCount    = 0;
  int activeCycles = 0;
  logic [7:0] expQ [$];

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (bus.rx_done === 1'b1)      doneCount++;
    if (bus.rx_frame_err === 1'b1) ferrCount++;
    if (bus.rx_active === 1'b1)    activeCycles++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame bits go out LSB first: start, data[0..7], stop
  task automatic drive_bits(input logic [9:0] frame, input int nbits, input int cpb);
    for (int i = 0; i < nbits; i++) begin
      bus.rx_serial = frame[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int cpb, input logic stop_bit);
    drive_bits({stop_bit, data, 1'b0}, 10, cpb);
  endtask

  task automatic pop_byte(output logic [7:0] b, output logic rdy);
    b = bus.rx_byte;
    rdy = bus.rx_ready;
    bus.rx_rd = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_serial = 1'b1;
    bus.rx_rd = 1'b0;
    bus.clk_per_bit = CPB_9600_32M;
    idle(4);
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 0", bus.rx_ready); end
    vectors++; if (bus.rx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", bus.rx_done); end
    vectors++; if (bus.rx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_active: got %b want 0", bus.rx_active); end
    vectors++; if (bus.rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ferr: got %b want 0", bus.rx_frame_err); end
    vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b want 0", bus.rx_overrun); end
    vectors++; if (bus.rx_byte !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_byte: got %h want 00", bus.rx_byte); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_baud_9600();
    int d0;
    logic [7:0] b;
    logic rdy;
    d0 = doneCount;
    bus.clk_per_bit = CPB_9600_32M;
    expQ.push_back(8'hAF);
    send_frame(8'hAF, int'(CPB_9600_32M), 1'b1);
    idle(4);
    vectors++; if (doneCount - d0 !== 1) begin miscompares++; $display("[TB] FAIL b9600_done: got %0d want 1", doneCount - d0); end
    vectors++; if (bus.rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b9600_ready: got %b want 1", bus.rx_ready); end
    pop_byte(b, rdy);
    vectors++; if (b !== expQ[0]) begin miscompares++; $display("[TB] FAIL b9600_byte: got %h want %h", b, expQ[0]); end
    void'(expQ.pop_front());
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b9600_ready_after_rd: got %b want 0", bus.rx_ready); end
  endtask

  task automatic test_back_to_back();
    int d0;
    int expDone;
    logic [7:0] b;
    logic rdy;
    d0 = doneCount;
    bus.clk_per_bit = 12'd16;
    fork
      send_frame(8'h55, 16, 1'b1);
      begin
        idle(40);
        bus.clk_per_bit = 12'd40;
      end
    join
    bus.clk_per_bit = 12'd16;
    send_frame(8'hCD, 16, 1'b1);
    idle(4);
    expQ.push_back(8'h55);
`ifdef UART_RX_FIFO_EN
    expQ.push_back(8'hCD);
    expDone = 2;
    vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun: got %b want 0", bus.rx_overrun); end
`else
    expDone = 1;
    vectors++; if (bus.rx_overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_overrun: got %b want 1", bus.rx_overrun); end
`endif
    vectors++; if (doneCount - d0 !== expDone) begin miscompares++; $display("[TB] FAIL b2b_done: got %0d want %0d", doneCount - d0, expDone); end
    while (expQ.size() > 0) begin
      pop_byte(b, rdy);
      vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready: got %b want 1", rdy); end
      vectors++; if (b !== expQ[0]) begin miscompares++; $display("[TB] FAIL b2b_byte: got %h want %h", b, expQ[0]); end
      void'(expQ.pop_front());
    end
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drained: got %b want 0", bus.rx_ready); end
    vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun_clr: got %b want 0", bus.rx_overrun); end
  endtask

  task automatic test_glitch();
    int d0, f0, a0;
    d0 = doneCount;
    f0 = ferrCount;
    a0 = activeCycles;
    bus.clk_per_bit = 12'd16;
    bus.rx_serial = 1'b0;
    idle(5);
    bus.rx_serial = 1'b1;
    idle(40);
    vectors++; if (activeCycles - a0 !== 8) begin miscompares++; $display("[TB] FAIL glitch_active_len: got %0d want 8", activeCycles - a0); end
    vectors++; if (bus.rx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_active: got %b want 0", bus.rx_active); end
    vectors++; if (doneCount - d0 !== 0) begin miscompares++; $display("[TB] FAIL glitch_done: got %0d want 0", doneCount - d0); end
    vectors++; if (ferrCount - f0 !== 0) begin miscompares++; $display("[TB] FAIL glitch_ferr: got %0d want 0", ferrCount - f0); end
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_ready: got %b want 0", bus.rx_ready); end
  endtask

  task automatic test_frame_error();
    int d0, f0;
    logic [7:0] b;
    logic rdy;
    d0 = doneCount;
    f0 = ferrCount;
    bus.clk_per_bit = 12'd16;
    send_frame(8'h3C, 16, 1'b0);
    idle(32);
    vectors++; if (bus.rx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_break_active: got %b want 0", bus.rx_active); end
    bus.rx_serial = 1'b1;
    idle(8);
    vectors++; if (ferrCount - f0 !== 1) begin miscompares++; $display("[TB] FAIL ferr_pulse: got %0d want 1", ferrCount - f0); end
    vectors++; if (doneCount - d0 !== 0) begin miscompares++; $display("[TB] FAIL ferr_done: got %0d want 0", doneCount - d0); end
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_ready: got %b want 0", bus.rx_ready); end
    expQ.push_back(8'h81);
    send_frame(8'h81, 16, 1'b1);
    idle(4);
    vectors++; if (doneCount - d0 !== 1) begin miscompares++; $display("[TB] FAIL ferr_next_done: got %0d want 1", doneCount - d0); end
    pop_byte(b, rdy);
    vectors++; if (b !== expQ[0]) begin miscompares++; $display("[TB] FAIL ferr_next_byte: got %h want %h", b, expQ[0]); end
    void'(expQ.pop_front());
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    logic [7:0] b;
    logic rdy;
    bus.clk_per_bit = 12'd16;
    expQ.push_back(8'h3E);
    send_frame(8'h3E, 16, 1'b1);
    idle(2);
    vectors++; if (bus.rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_pre_ready: got %b want 1", bus.rx_ready); end
    drive_bits({1'b1, 8'hC3, 1'b0}, 5, 16);
    bus.rx_serial = 1'b0;
    idle(8);
    vectors++; if (bus.rx_active !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_in_frame: got %b want 1", bus.rx_active); end
    rst = 1'b1;
    expQ.delete();
    #1;
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_ready: got %b want 0", bus.rx_ready); end
    vectors++; if (bus.rx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_active: got %b want 0", bus.rx_active); end
    vectors++; if (bus.rx_byte !== 8'h00) begin miscompares++; $display("[TB] FAIL rmid_byte: got %h want 00", bus.rx_byte); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rx_serial = 1'b1;
    idle(20);
    d0 = doneCount;
    expQ.push_back(8'hA5);
    send_frame(8'hA5, 16, 1'b1);
    idle(4);
    vectors++; if (doneCount - d0 !== 1) begin miscompares++; $display("[TB] FAIL rmid_next_done: got %0d want 1", doneCount - d0); end
    pop_byte(b, rdy);
    vectors++; if (b !== expQ[0]) begin miscompares++; $display("[TB] FAIL rmid_next_byte: got %h want %h", b, expQ[0]); end
    void'(expQ.pop_front());
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_drained: got %b want 0", bus.rx_ready); end
  endtask

  task automatic test_push_pop_full();
    int d0;
    logic [7:0] b;
    logic [7:0] obs;
    logic rdy;
    bus.clk_per_bit = 12'd16;
    for (int i = 0; i < STORE_DEPTH; i++) begin
      expQ.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 16, 1'b1);
    end
    idle(4);
    vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL full_pre_overrun: got %b want 0", bus.rx_overrun); end
    d0 = doneCount;
    obs = 8'h00;
    // Stop-bit sample lands on the 155th edge after the start edge at cpb=16
    fork
      send_frame(8'h9B, 16, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        obs = bus.rx_byte;
        bus.rx_rd = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_rd = 1'b0;
      end
    join
    vectors++; if (obs !== expQ[0]) begin miscompares++; $display("[TB] FAIL full_popped_oldest: got %h want %h", obs, expQ[0]); end
    void'(expQ.pop_front());
    expQ.push_back(8'h9B);
    idle(4);
    vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL full_overrun: got %b want 0", bus.rx_overrun); end
    vectors++; if (doneCount - d0 !== 1) begin miscompares++; $display("[TB] FAIL full_done: got %0d want 1", doneCount - d0); end
    while (expQ.size() > 0) begin
      pop_byte(b, rdy);
      vectors++; if (b !== expQ[0] || rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL full_drain: got %h/%b want %h/1", b, rdy, expQ[0]); end
      void'(expQ.pop_front());
    end
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_drained: got %b want 0", bus.rx_ready); end
  endtask

  initial begin
    test_reset();
    test_baud_9600();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_push_pop_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
